// File: rtl/riscv_cpu_top_pkg.sv
// Shared RV32I encodings, ALU op set and decode/datapath record types for the
// single-cycle core.
package riscv_cpu_top_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM, WB_AUIPC} wb_sel_e;

  typedef struct packed {
    logic    reg_we;
    logic    mem_we;
    logic    alu_imm;
    logic    is_branch;
    logic    is_jal;
    logic    is_jalr;
    wb_sel_e wb_sel;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } dmem_req_t;

  // alt selects SUB/SRA; caller masks it for OP-IMM so ADDI never becomes SUB
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_cpu_top_regfile.sv
// 32x32 register file: two combinational read ports, one write port on the
// rising edge, x0 hardwired to zero, async active-low clear.
module riscv_cpu_top_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && rd_addr != 5'd0) begin
      regs[rd_addr] <= rd_data;
    end
  end

  // reads see the pre-edge value even when the same register is being written
  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/riscv_cpu_top.sv
// Single-cycle RV32I core: ROM fetch, decode, ALU, data RAM and writeback all
// resolve in one cycle; pc and register/memory state commit on the rising edge.
module riscv_cpu_top
  import riscv_cpu_top_pkg::*;
#(
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 1024,
  parameter string       IMEM_INIT  = "program.hex",
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);

  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [31:0] pc, pc_next, inst, imm, rs1_data, rs2_data, alu_out;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] alu_b, wb_data, ld_data, dm_rword;
  logic        br_taken, dm_in_range;
  logic [DAW-1:0] dm_idx;
  ctrl_t       c;
  dmem_req_t   dm_req;

  // ---------------- fetch ----------------
  logic [31:0] imem [0:IMEM_DEPTH-1];

  assign inst   = ({2'b00, pc[31:2]} < 32'(IMEM_DEPTH)) ? imem[pc[IAW+1:2]] : NOP_INST;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= RESET_PC;
    else      pc <= pc_next;
  end

  // ---------------- decode ----------------
  always_comb begin
    c        = '0;
    c.alu_op = ALU_ADD;
    c.wb_sel = WB_ALU;
    case (opcode)
      OPC_LUI:    begin c.reg_we = 1'b1; c.wb_sel = WB_IMM; end
      OPC_AUIPC:  begin c.reg_we = 1'b1; c.wb_sel = WB_AUIPC; end
      OPC_JAL:    begin c.reg_we = 1'b1; c.is_jal = 1'b1; c.wb_sel = WB_PC4; end
      OPC_JALR:   begin c.reg_we = 1'b1; c.is_jalr = 1'b1; c.alu_imm = 1'b1; c.wb_sel = WB_PC4; end
      OPC_BRANCH: c.is_branch = 1'b1;
      OPC_LOAD:   begin c.reg_we = 1'b1; c.alu_imm = 1'b1; c.wb_sel = WB_MEM; end
      OPC_STORE:  begin c.mem_we = 1'b1; c.alu_imm = 1'b1; end
      OPC_OP_IMM: begin
        c.reg_we  = 1'b1;
        c.alu_imm = 1'b1;
        c.alu_op  = alu_decode(funct3, (funct3 == F3_SR) && inst[30]);
      end
      OPC_OP:     begin c.reg_we = 1'b1; c.alu_op = alu_decode(funct3, inst[30]); end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: ;
    endcase
  end

  always_comb begin
    imm = '0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm = {inst[31:12], 12'h000};
      OPC_JAL:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:    imm = '0;
    endcase
  end

  riscv_cpu_top_regfile regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (inst[19:15]),
    .rs2_addr (inst[24:20]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (c.reg_we),
    .rd_addr  (inst[11:7]),
    .rd_data  (wb_data)
  );

  // ---------------- execute ----------------
  assign alu_b = c.alu_imm ? imm : rs2_data;

  always_comb begin
    alu_out = '0;
    case (c.alu_op)
      ALU_ADD:  alu_out = rs1_data + alu_b;
      ALU_SUB:  alu_out = rs1_data - alu_b;
      ALU_SLL:  alu_out = rs1_data << alu_b[4:0];
      ALU_SLT:  alu_out = {31'b0, $signed(rs1_data) < $signed(alu_b)};
      ALU_SLTU: alu_out = {31'b0, rs1_data < alu_b};
      ALU_XOR:  alu_out = rs1_data ^ alu_b;
      ALU_SRL:  alu_out = rs1_data >> alu_b[4:0];
      ALU_SRA:  alu_out = 32'($signed(rs1_data) >>> alu_b[4:0]);
      ALU_OR:   alu_out = rs1_data | alu_b;
      ALU_AND:  alu_out = rs1_data & alu_b;
      default:  alu_out = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_data == rs2_data);
      F3_BNE:  br_taken = (rs1_data != rs2_data);
      F3_BLT:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: br_taken = (rs1_data <  rs2_data);
      F3_BGEU: br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_next = pc + 32'd4;
    if (c.is_jal || (c.is_branch && br_taken)) pc_next = pc + imm;
    else if (c.is_jalr)                        pc_next = alu_out & ~32'd1;
  end

  // ---------------- data memory ----------------
  assign dm_in_range = ({2'b00, alu_out[31:2]} < 32'(DMEM_DEPTH));
  assign dm_idx      = alu_out[DAW+1:2];

  // halfword/word stores drop the low address bits rather than trapping
  always_comb begin
    dm_req       = '0;
    dm_req.addr  = alu_out;
    dm_req.we    = c.mem_we && dm_in_range && rst;
    case (funct3)
      F3_SB: begin dm_req.be = 4'b0001 << alu_out[1:0]; dm_req.wdata = {4{rs2_data[7:0]}}; end
      F3_SH: begin dm_req.be = alu_out[1] ? 4'b1100 : 4'b0011; dm_req.wdata = {2{rs2_data[15:0]}}; end
      F3_SW: begin dm_req.be = 4'b1111; dm_req.wdata = rs2_data; end
      default: dm_req.be = 4'b0000;
    endcase
  end

  if (1) begin : mem
    logic [31:0] mem [0:DMEM_DEPTH-1];

    always_ff @(posedge clk) begin
      if (dm_req.we) begin
        for (int b = 0; b < 4; b++)
          if (dm_req.be[b]) mem[dm_idx][8*b +: 8] <= dm_req.wdata[8*b +: 8];
      end
    end

    assign dm_rword = dm_in_range ? mem[dm_idx] : '0;
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = dm_rword[{dm_req.addr[1:0], 3'b000} +: 8];
    ld_half = dm_req.addr[1] ? dm_rword[31:16] : dm_rword[15:0];
    case (funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LW:   ld_data = dm_rword;
      F3_LBU:  ld_data = {24'h0, ld_byte};
      F3_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = dm_rword;
    endcase
  end

  // ---------------- writeback ----------------
  always_comb begin
    wb_data = alu_out;
    case (c.wb_sel)
      WB_MEM:   wb_data = ld_data;
      WB_PC4:   wb_data = pc + 32'd4;
      WB_IMM:   wb_data = imm;
      WB_AUIPC: wb_data = pc + imm;
      default:  wb_data = alu_out;
    endcase
  end

endmodule

// File: tb/tb_riscv_cpu_top.sv
// Lockstep bench: an instruction-set model runs beside the core, pc checked each
// cycle, architectural state checked after directed and random programs.
module tb_riscv_cpu_top;

  localparam int ID = 256;
  localparam int DD = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  riscv_cpu_top #(
    .IMEM_DEPTH (ID),
    .DMEM_DEPTH (DD),
    .IMEM_INIT  (""),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] prog [$];
  logic [31:0] t_imem [0:ID-1];
  logic [31:0] m_regs [0:31];
  logic [7:0]  m_mem  [0:4*DD-1];
  logic [31:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    logic [4:0] a, b, d;
    a = 5'(rs1); b = 5'(rs2); d = 5'(rd);
    return {f7, b, a, f3, d, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] v; logic [4:0] a, d;
    v = 12'(imm); a = 5'(rs1); d = 5'(rd);
    return {v, a, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [11:0] v; logic [4:0] a, b;
    v = 12'(imm); a = 5'(rs1); b = 5'(rs2);
    return {v[11:5], b, a, f3, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int off, input int rs1, input int rs2, input logic [2:0] f3);
    logic [12:0] v; logic [4:0] a, b;
    v = 13'(off); a = 5'(rs1); b = 5'(rs2);
    return {v[12], v[10:5], b, a, f3, v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int off, input int rd);
    logic [20:0] v; logic [4:0] d;
    v = 21'(off); d = 5'(rd);
    return {v[20], v[10:1], v[11], v[19:12], d, 7'h6F};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_rd8(input logic [31:0] a);
    return ((a >> 2) < 32'(DD)) ? m_mem[int'(a)] : 8'h00;
  endfunction

  function automatic void m_wr8(input logic [31:0] a, input logic [7:0] v);
    if ((a >> 2) < 32'(DD)) m_mem[int'(a)] = v;
  endfunction

  function automatic logic [31:0] m_word(input int w);
    return {m_mem[4*w+3], m_mem[4*w+2], m_mem[4*w+1], m_mem[4*w]};
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] ea, input logic [2:0] f3);
    logic [31:0] h, w;
    h = ea & ~32'd1;
    w = ea & ~32'd3;
    case (f3)
      3'd0: return 32'($signed(m_rd8(ea)));
      3'd1: return 32'($signed({m_rd8(h + 1), m_rd8(h)}));
      3'd2: return {m_rd8(w + 3), m_rd8(w + 2), m_rd8(w + 1), m_rd8(w)};
      3'd4: return {24'h0, m_rd8(ea)};
      3'd5: return {16'h0, m_rd8(h + 1), m_rd8(h)};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_store(input logic [31:0] ea, input logic [2:0] f3, input logic [31:0] v);
    logic [31:0] h, w;
    h = ea & ~32'd1;
    w = ea & ~32'd3;
    case (f3)
      3'd0: m_wr8(ea, v[7:0]);
      3'd1: begin m_wr8(h, v[7:0]); m_wr8(h + 1, v[15:8]); end
      3'd2: for (int k = 0; k < 4; k++) m_wr8(w + 32'(k), v[8*k +: 8]);
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] m_alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic void m_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endfunction

  function automatic void m_step();
    logic [31:0] in, a, b, ii, si, bi, ui, ji, nx, r;
    logic [4:0] rd;
    logic [2:0] f3;
    logic wr, tk;
    in = ((m_pc >> 2) < 32'(ID)) ? t_imem[int'(m_pc >> 2)] : 32'h0000_0013;
    rd = in[11:7]; f3 = in[14:12];
    a  = m_regs[in[19:15]]; b = m_regs[in[24:20]];
    ii = {{20{in[31]}}, in[31:20]};
    si = {{20{in[31]}}, in[31:25], in[11:7]};
    bi = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
    ui = {in[31:12], 12'h0};
    ji = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
    nx = m_pc + 4; wr = 1'b1; r = 32'h0; tk = 1'b0;
    case (in[6:0])
      7'h37: r = ui;
      7'h17: r = m_pc + ui;
      7'h6F: begin r = m_pc + 4; nx = m_pc + ji; end
      7'h67: begin r = m_pc + 4; nx = (a + ii) & ~32'd1; end
      7'h63: begin
        wr = 1'b0;
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) <  $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a <  b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) nx = m_pc + bi;
      end
      7'h03: r = m_load(a + ii, f3);
      7'h23: begin wr = 1'b0; m_store(a + si, f3, b); end
      7'h13: r = m_alu(f3, (f3 == 3'd5) && in[30], a, ii);
      7'h33: r = m_alu(f3, in[30], a, b);
      default: wr = 1'b0;
    endcase
    if (wr && rd != 5'd0) m_regs[rd] = r;
    m_pc = nx;
  endfunction

  // ---------------- sequencing ----------------
  task automatic load_prog();
    for (int i = 0; i < ID; i++) begin
      t_imem[i] = 32'h0000_0013;
      dut.imem[i] = 32'h0000_0013;
    end
    foreach (prog[i]) begin
      t_imem[i] = prog[i];
      dut.imem[i] = prog[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_reset();
    repeat (10) @(negedge clk);
    chk("rst_pc", dut.pc, 32'h0);
    for (int i = 1; i < 32; i++) chk($sformatf("rst_x%0d", i), dut.regfile.regs[i], 32'h0);
    rst = 1'b1;
  endtask

  // called at a falling edge; checks pc and advances the model once per cycle
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      chk("pc", dut.pc, m_pc);
      m_step();
      @(negedge clk);
    end
  endtask

  task automatic cmp_regs(input string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s_x%0d", tag, i), dut.regfile.regs[i], m_regs[i]);
  endtask

  function automatic logic [31:0] rnd_inst();
    int k, rd, rs1, rs2, off;
    logic [2:0] f3;
    logic [31:0] ins;
    logic [2:0] lds [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] brs [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    k = $urandom_range(0, 9);
    rd = $urandom_range(0, 31); rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
    f3 = 3'($urandom_range(0, 7));
    off = ($urandom_range(0, 7) == 0) ? $urandom_range(1024, 2047) : $urandom_range(0, 255);
    case (k)
      0, 1: ins = enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                        rs2, rs1, f3, rd);
      2, 3: begin
        if (f3 == 3'd1) ins = enc_i($urandom_range(0, 31), rs1, f3, rd, 7'h13);
        else if (f3 == 3'd5) ins = enc_i($urandom_range(0, 31) + ($urandom_range(0, 1) * 1024), rs1, f3, rd, 7'h13);
        else ins = enc_i($urandom_range(0, 4095), rs1, f3, rd, 7'h13);
      end
      4: ins = {20'($urandom), 5'(rd), ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17};
      5: ins = enc_i(off, 0, lds[$urandom_range(0, 4)], rd, 7'h03);
      6: ins = enc_s(off, rs2, 0, 3'($urandom_range(0, 2)));
      7: ins = enc_b(4 * $urandom_range(1, 4), rs1, rs2, brs[$urandom_range(0, 5)]);
      8: ins = enc_j(4 * $urandom_range(1, 3), rd);
      default: case ($urandom_range(0, 2))
        0: ins = 32'h0000_000F;
        1: ins = {25'h0, 7'h73};
        default: ins = {25'($urandom), 7'h7F};
      endcase
    endcase
    return ins;
  endfunction

  initial begin
    for (int i = 0; i < 4*DD; i++) m_mem[i] = 8'h00;

    // arithmetic, x0 writes ignored, pc advances by 4 after release
    prog = '{enc_i(5, 0, 3'd0, 28, 7'h13), enc_i(-3, 0, 3'd0, 29, 7'h13),
             enc_r(7'h00, 29, 28, 3'd0, 30), enc_r(7'h20, 29, 28, 3'd0, 5),
             enc_i(7, 0, 3'd0, 0, 7'h13)};
    load_prog(); do_reset();
    run(1);
    chk("pc_after_release", dut.pc, 32'h4);
    run(7);
    chk("arith_x28", dut.regfile.regs[28], 32'd5);
    chk("arith_x29", dut.regfile.regs[29], 32'hFFFF_FFFD);
    chk("arith_x30", dut.regfile.regs[30], 32'd2);
    chk("arith_x5",  dut.regfile.regs[5],  32'd8);
    chk("arith_x0",  dut.regfile.regs[0],  32'd0);
    cmp_regs("arith");

    // byte/half/word load-store lanes
    prog = '{enc_i(32'h123, 0, 3'd0, 1, 7'h13), enc_s(8, 1, 0, 3'd2),
             enc_i(8, 0, 3'd0, 2, 7'h03), enc_i(8, 0, 3'd5, 3, 7'h03),
             enc_s(9, 0, 0, 3'd0), enc_i(8, 0, 3'd2, 4, 7'h03)};
    load_prog(); do_reset();
    run(2);
    chk("mem2_after_sw", dut.mem.mem[2], 32'h0000_0123);
    run(6);
    chk("ld_x2", dut.regfile.regs[2], 32'h0000_0023);
    chk("ld_x3", dut.regfile.regs[3], 32'h0000_0123);
    chk("ld_x4", dut.regfile.regs[4], 32'h0000_0023);
    chk("mem2_after_sb", dut.mem.mem[2], 32'h0000_0023);
    cmp_regs("ldst");

    // countdown loop; then async reset between edges in the middle of it
    prog = '{enc_i(10, 0, 3'd0, 15, 7'h13), enc_i(-1, 15, 3'd0, 15, 7'h13),
             enc_b(-4, 15, 0, 3'd1), enc_j(8, 1)};
    load_prog(); do_reset();
    run(30);
    chk("loop_x15", dut.regfile.regs[15], 32'd0);
    chk("loop_x1",  dut.regfile.regs[1],  32'd16);
    cmp_regs("loop");
    do_reset();
    run(9);
    #2 rst = 1'b0;
    #1;
    m_reset();
    chk("async_pc", dut.pc, 32'h0);
    for (int i = 1; i < 32; i++) chk($sformatf("async_x%0d", i), dut.regfile.regs[i], 32'h0);
    chk("async_mem2", dut.mem.mem[2], 32'h0000_0023);
    do_reset();
    run(30);
    cmp_regs("loop2");

    // shifts and compares on a negative operand
    prog = '{enc_i(-8, 0, 3'd0, 6, 7'h13), enc_i(32'h401, 6, 3'd5, 7, 7'h13),
             enc_i(28, 6, 3'd5, 8, 7'h13), enc_r(7'h00, 0, 6, 3'd2, 9),
             enc_r(7'h00, 0, 6, 3'd3, 10)};
    load_prog(); do_reset();
    run(8);
    chk("sh_x7",  dut.regfile.regs[7],  32'hFFFF_FFFC);
    chk("sh_x8",  dut.regfile.regs[8],  32'h0000_000F);
    chk("sh_x9",  dut.regfile.regs[9],  32'd1);
    chk("sh_x10", dut.regfile.regs[10], 32'd0);
    cmp_regs("shift");

    // random programs: RAM cleared by the program itself, ends by jumping off the ROM
    for (int t = 0; t < 3; t++) begin
      prog = {};
      for (int w = 0; w < DD; w++) prog.push_back(enc_s(4 * w, 0, 0, 3'd2));
      for (int n = 0; n < 120; n++) prog.push_back(rnd_inst());
      prog.push_back(enc_i(32'h7FC, 0, 3'd0, 0, 7'h67));
      load_prog(); do_reset();
      run(220);
      cmp_regs($sformatf("rnd%0d", t));
      for (int w = 0; w < DD; w++) chk($sformatf("rnd%0d_mem%0d", t, w), dut.mem.mem[w], m_word(w));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
